// File: rtl/nonce_scanner_pkg.sv
// Shared types, widths and helpers for the nonce scanner and its comparator.
package nonce_scanner_pkg;

  localparam int HDR_W   = 640;  // full 80-byte block header
  localparam int TPL_W   = 608;  // header bytes 0..75 (everything but the nonce)
  localparam int NONCE_W = 32;
  localparam int HASH_W  = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_CHECK,
    ST_DRAIN,
    ST_FOUND,
    ST_EXHAUSTED,
    ST_ERROR
  } state_t;

  // The nonce is an integer internally but is serialised little-endian in the header.
  function automatic logic [NONCE_W-1:0] bswap32(input logic [NONCE_W-1:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/nonce_scanner_cmp.sv
// Digest-vs-target comparator: the core emits digest byte 0 first, but Bitcoin
// treats the digest as a little-endian integer, so byte 31 becomes the MSB.
module hash_target_cmp
  import nonce_scanner_pkg::*;
(
  input  logic [HASH_W-1:0] hash_in,
  input  logic [HASH_W-1:0] target,
  output logic              hit
);

  logic [HASH_W-1:0] w_value;

  genvar gi;
  generate
    for (gi = 0; gi < HASH_W / 8; gi++) begin : g_rev
      assign w_value[8*gi +: 8] = hash_in[8*(HASH_W/8 - 1 - gi) +: 8];
    end
  endgenerate

  // Inclusive unsigned compare: a digest equal to the target still wins.
  assign hit = (w_value <= target);

endmodule

// File: rtl/nonce_scanner.sv
// Nonce sweep controller: launches one double-SHA256 per nonce on the external
// core, checks each digest against the target, stops on the first hit, on
// range exhaustion, on a core timeout, or on abort.
module nonce_scanner
  import nonce_scanner_pkg::*;
#(
  parameter int HASH_TIMEOUT = 1023,
  parameter int TO_W         = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                abort,
  input  logic [TPL_W-1:0]    template_in,
  input  logic [HASH_W-1:0]   target,
  input  logic [NONCE_W-1:0]  nonce_start,
  input  logic [NONCE_W-1:0]  nonce_end,
  output logic                hash_start,
  output logic [HDR_W-1:0]    hash_block,
  input  logic                hash_done,
  input  logic [HASH_W-1:0]   hash_in,
  output logic                busy,
  output logic                found,
  output logic                exhausted,
  output logic                error,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic [HASH_W-1:0]   found_hash,
  output logic [NONCE_W-1:0]  nonce_cur,
  output logic [31:0]         hashes_done
);

  // The counter is cleared in LAUNCH and first reads 0 in the cycle after
  // hash_start, so leaving WAIT when it reads HASH_TIMEOUT-2 puts the error
  // flag up exactly HASH_TIMEOUT cycles after the launch pulse.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(HASH_TIMEOUT - 2);

  state_t              r_state;
  logic [TPL_W-1:0]    r_template;
  logic [HASH_W-1:0]   r_target;
  logic [NONCE_W-1:0]  r_nonce_end;
  logic [NONCE_W-1:0]  r_nonce_cur;
  logic [HASH_W-1:0]   r_hash_q;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_hash_start;
  logic                r_busy;
  logic                r_found;
  logic                r_exhausted;
  logic                r_error;
  logic [NONCE_W-1:0]  r_found_nonce;
  logic [HASH_W-1:0]   r_found_hash;
  logic [31:0]         r_hashes_done;

  logic                w_hit;
  logic                w_to_expire;

  hash_target_cmp u_cmp (
    .hash_in (r_hash_q),
    .target  (r_target),
    .hit     (w_hit)
  );

  // >= rather than == so DRAIN still exits if abort lands on the final WAIT cycle.
  assign w_to_expire = (r_to_cnt >= TO_LAST);

  // Scan state machine; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_template    <= '0;
      r_target      <= '0;
      r_nonce_end   <= '0;
      r_nonce_cur   <= '0;
      r_hash_q      <= '0;
      r_to_cnt      <= '0;
      r_hash_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_found       <= 1'b0;
      r_exhausted   <= 1'b0;
      r_error       <= 1'b0;
      r_found_nonce <= '0;
      r_found_hash  <= '0;
      r_hashes_done <= '0;
    end else begin
      r_hash_start <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_ERROR: begin
          // abort beats a simultaneous run: nothing changes
          if (run && !abort) begin
            r_template    <= template_in;
            r_target      <= target;
            r_nonce_end   <= nonce_end;
            r_nonce_cur   <= nonce_start;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_error       <= 1'b0;
            r_found_nonce <= '0;
            r_found_hash  <= '0;
            r_hashes_done <= '0;
            r_hash_start  <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ST_LAUNCH;
          end
        end

        ST_LAUNCH: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_to_cnt <= '0;
            r_state  <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (abort && hash_done) begin
            // the digest we would have drained is already here; discard it
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (abort) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            r_state  <= ST_DRAIN;
          end else if (hash_done) begin
            r_hash_q <= hash_in;
            if (r_hashes_done != 32'hFFFF_FFFF) begin
              r_hashes_done <= r_hashes_done + 32'd1;
            end
            r_state <= ST_CHECK;
          end else if (w_to_expire) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_ERROR;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        ST_CHECK: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_hit) begin
            r_found       <= 1'b1;
            r_found_nonce <= r_nonce_cur;
            r_found_hash  <= r_hash_q;
            r_busy        <= 1'b0;
            r_state       <= ST_FOUND;
          end else if (r_nonce_cur == r_nonce_end) begin
            r_exhausted <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_EXHAUSTED;
          end else begin
            // wraps naturally through FFFFFFFF -> 00000000
            r_nonce_cur  <= r_nonce_cur + 32'd1;
            r_hash_start <= 1'b1;
            r_state      <= ST_LAUNCH;
          end
        end

        ST_DRAIN: begin
          // swallow the in-flight digest so it cannot land in the next run
          if (hash_done || w_to_expire) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign hash_start  = r_hash_start;
  assign hash_block  = {r_template, bswap32(r_nonce_cur)};
  assign busy        = r_busy;
  assign found       = r_found;
  assign exhausted   = r_exhausted;
  assign error       = r_error;
  assign found_nonce = r_found_nonce;
  assign found_hash  = r_found_hash;
  assign nonce_cur   = r_nonce_cur;
  assign hashes_done = r_hashes_done;

endmodule

// File: tb/tb_nonce_scanner.sv
// Directed bench for nonce_scanner with a stub double-SHA256 core that returns
// the genesis digest for the genesis nonce and all-ones for every other nonce.
module tb_nonce_scanner;

  localparam int HT  = 1023;
  localparam int LAT = 100;

  localparam logic [607:0] GEN_TPL = {
    32'h01000000,
    256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49,
    32'hffff001d
  };
  localparam logic [255:0] GEN_RAW = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [255:0] GEN_VAL = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
  localparam logic [255:0] GEN_TGT = {32'h0, 16'hffff, 208'h0};
  localparam logic [255:0] ONES    = {256{1'b1}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic          abort;
  logic [607:0]  template_in;
  logic [255:0]  target;
  logic [31:0]   nonce_start;
  logic [31:0]   nonce_end;
  logic          hash_start;
  logic [639:0]  hash_block;
  logic          hash_done;
  logic [255:0]  hash_in;
  logic          busy;
  logic          found;
  logic          exhausted;
  logic          error;
  logic [31:0]   found_nonce;
  logic [255:0]  found_hash;
  logic [31:0]   nonce_cur;
  logic [31:0]   hashes_done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nonce_scanner #(.HASH_TIMEOUT(HT), .TO_W(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .abort       (abort),
    .template_in (template_in),
    .target      (target),
    .nonce_start (nonce_start),
    .nonce_end   (nonce_end),
    .hash_start  (hash_start),
    .hash_block  (hash_block),
    .hash_done   (hash_done),
    .hash_in     (hash_in),
    .busy        (busy),
    .found       (found),
    .exhausted   (exhausted),
    .error       (error),
    .found_nonce (found_nonce),
    .found_hash  (found_hash),
    .nonce_cur   (nonce_cur),
    .hashes_done (hashes_done)
  );

  // Stub core: fixed latency, answer depends only on the nonce lane.
  logic        core_en;
  logic        pend;
  int          cnt;
  logic [31:0] blk_nonce;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_done <= 1'b0;
      hash_in   <= '0;
      pend      <= 1'b0;
      cnt       <= 0;
      blk_nonce <= '0;
    end else begin
      hash_done <= 1'b0;
      if (hash_start) begin
        pend      <= core_en;
        cnt       <= LAT;
        blk_nonce <= hash_block[31:0];
      end else if (pend) begin
        if (cnt == 1) begin
          hash_done <= 1'b1;
          hash_in   <= (blk_nonce == 32'h1dac2b7c) ? GEN_RAW : ONES;
          pend      <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // Record every launch and the nonce lane presented with it.
  int          n_starts = 0;
  logic [31:0] q_lane[$];
  always @(posedge clk) begin
    if (hash_start) begin
      n_starts <= n_starts + 1;
      q_lane.push_back(hash_block[31:0]);
    end
  end

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called on a negedge; returns on the negedge after run was sampled.
  // Config inputs are scrambled afterwards to prove they were latched.
  task automatic start_run(input logic [607:0] tpl, input logic [255:0] tgt,
                           input logic [31:0] s, input logic [31:0] e);
    template_in = tpl;
    target      = tgt;
    nonce_start = s;
    nonce_end   = e;
    run         = 1'b1;
    @(negedge clk);
    run         = 1'b0;
    template_in = ~tpl;
    target      = ~tgt;
    nonce_start = ~s;
    nonce_end   = ~e;
  endtask

  task automatic wait_idle(input int limit, output int cyc);
    cyc = 0;
    while (busy !== 1'b0 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    chk("idle_reached", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int s0;
    int qb;
    int k;
    logic [31:0] exp_lane [4];
    exp_lane = '{32'hFEFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h01000000};

    rst_n = 1'b0; run = 1'b0; abort = 1'b0; core_en = 1'b1;
    template_in = '0; target = '0; nonce_start = '0; nonce_end = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy",      busy,        1'b0);
    chk("rst_found",     found,       1'b0);
    chk("rst_exh",       exhausted,   1'b0);
    chk("rst_err",       error,       1'b0);
    chk("rst_start",     hash_start,  1'b0);
    chk("rst_block",     hash_block,  640'h0);
    chk("rst_hashes",    hashes_done, 32'h0);
    chk("rst_fnonce",    found_nonce, 32'h0);
    chk("rst_fhash",     found_hash,  256'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Genesis: hit on third nonce
    s0 = n_starts;
    start_run(GEN_TPL, GEN_TGT, 32'h7C2BAC1B, 32'h7C2BAC20);
    chk("gen_launch", hash_start, 1'b1);
    wait_idle(2000, cyc);
    chk("gen_found",   found,            1'b1);
    chk("gen_exh",     exhausted,        1'b0);
    chk("gen_fnonce",  found_nonce,      32'h7C2BAC1D);
    chk("gen_hashes",  hashes_done,      32'd3);
    chk("gen_fhash",   found_hash,       GEN_RAW);
    chk("gen_starts",  n_starts - s0,    3);
    chk("gen_block",   hash_block,       {GEN_TPL, 32'h1dac2b7c});

    // Target zero: sweep five nonces, no hit
    s0 = n_starts;
    start_run(GEN_TPL, 256'h0, 32'h00000010, 32'h00000014);
    wait_idle(2000, cyc);
    chk("ex_exh",     exhausted,     1'b1);
    chk("ex_found",   found,         1'b0);
    chk("ex_hashes",  hashes_done,   32'd5);
    chk("ex_starts",  n_starts - s0, 5);
    chk("ex_ncur",    nonce_cur,     32'h00000014);

    // Wrap through FFFFFFFF -> 00000000
    qb = q_lane.size();
    start_run(GEN_TPL, 256'h0, 32'hFFFFFFFE, 32'h00000001);
    wait_idle(2000, cyc);
    chk("wr_exh",    exhausted,         1'b1);
    chk("wr_hashes", hashes_done,       32'd4);
    chk("wr_count",  q_lane.size() - qb, 4);
    for (int i = 0; i < 4; i++) begin
      if (qb + i < q_lane.size()) chk($sformatf("wr_lane%0d", i), q_lane[qb+i], exp_lane[i]);
    end

    // All-ones target, single nonce: all-ones digest wins (inclusive)
    start_run(GEN_TPL, ONES, 32'h12345678, 32'h12345678);
    wait_idle(2000, cyc);
    chk("one_found",  found,            1'b1);
    chk("one_fnonce", found_nonce,      32'h12345678);
    chk("one_lane",   hash_block[31:0], 32'h78563412);
    chk("one_hashes", hashes_done,      32'd1);
    chk("one_fhash",  found_hash,       ONES);

    // Target exactly equal to the digest value
    start_run(GEN_TPL, GEN_VAL, 32'h7C2BAC1D, 32'h7C2BAC1D);
    wait_idle(2000, cyc);
    chk("eq_found", found, 1'b1);

    // Target one below the digest value
    start_run(GEN_TPL, GEN_VAL - 256'd1, 32'h7C2BAC1D, 32'h7C2BAC1D);
    wait_idle(2000, cyc);
    chk("lt_found", found,     1'b0);
    chk("lt_exh",   exhausted, 1'b1);

    // run together with abort in a terminal state: nothing happens
    target = ONES; nonce_start = 32'h5; nonce_end = 32'h5; template_in = '0;
    run = 1'b1; abort = 1'b1;
    @(negedge clk);
    run = 1'b0; abort = 1'b0;
    chk("ra_start", hash_start, 1'b0);
    repeat (3) @(negedge clk);
    chk("ra_busy",   busy,        1'b0);
    chk("ra_exh",    exhausted,   1'b1);
    chk("ra_hashes", hashes_done, 32'd1);

    // Abort 50 cycles into the second hash: drain until done, then idle
    start_run(GEN_TPL, 256'h0, 32'h0, 32'h2);
    cyc = 0;
    while (!(hash_start === 1'b1 && hashes_done == 32'd1) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("ab_launch2", hash_start, 1'b1);
    repeat (50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    k = 51;
    chk("ab_drain_busy", busy, 1'b1);
    while (busy !== 1'b0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("ab_idle_at", k, LAT + 2);
    chk("ab_found",   found,       1'b0);
    chk("ab_exh",     exhausted,   1'b0);
    chk("ab_err",     error,       1'b0);
    chk("ab_hashes",  hashes_done, 32'd1);

    // Clean run right after the drained abort
    start_run(GEN_TPL, GEN_TGT, 32'h7C2BAC1D, 32'h7C2BAC1E);
    wait_idle(2000, cyc);
    chk("cl_found",  found,       1'b1);
    chk("cl_fnonce", found_nonce, 32'h7C2BAC1D);
    chk("cl_hashes", hashes_done, 32'd1);

    // Dead core: error exactly HT cycles after hash_start
    core_en = 1'b0;
    start_run(GEN_TPL, ONES, 32'h5, 32'h5);
    chk("to_launch", hash_start, 1'b1);
    k = 0;
    while (error !== 1'b1 && k < HT + 50) begin
      @(negedge clk);
      k++;
    end
    chk("to_cycles", k,     HT);
    chk("to_err",    error, 1'b1);
    chk("to_busy",   busy,  1'b0);
    core_en = 1'b1;
    start_run(GEN_TPL, ONES, 32'h5, 32'h5);
    chk("to_clear", error, 1'b0);
    wait_idle(2000, cyc);
    chk("to_refound", found, 1'b1);

    // Reset in the middle of a scan
    start_run(GEN_TPL, 256'h0, 32'h0, 32'h9);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_busy",   busy,        1'b0);
    chk("mr_hashes", hashes_done, 32'h0);
    chk("mr_ncur",   nonce_cur,   32'h0);
    chk("mr_block",  hash_block,  640'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mr_stay", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nonce_scanner.md
Name: nonce_scanner

Overview:
Mining controller sitting directly upstream and downstream of the double-SHA256 core. It holds an 80-byte header template and sweeps the 32-bit nonce field across a programmed range. For each nonce it launches one hash on the core, waits for the digest, and compares it against the target using Bitcoin's little-endian integer convention. It reports the first winning nonce/hash, or reports range exhaustion.

Parameters:
HASH_TIMEOUT, 1023, max cycles to wait for hash_done after launch before flagging error (must be > core latency, ~250 cycles)
TO_W, 10, width of timeout counter (must hold HASH_TIMEOUT)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
run  in  1  one-cycle pulse; sampled only in IDLE; latches config and starts scan
abort  in  1  level/pulse; requests scan stop
template_in  in  608  header bytes 0..75, byte 0 at [607:600]
target  in  256  difficulty target as big integer, MSB at [255]
nonce_start  in  32  first nonce (integer)
nonce_end  in  32  last nonce inclusive (integer)
hash_start  out  1  one-cycle launch pulse to core
hash_block  out  640  {template_q, bswap32(nonce_cur)}; stable from launch until hash_done
hash_done  in  1  core completion pulse
hash_in  in  256  core digest, digest byte 0 at [255:248]; valid when hash_done=1
busy  out  1  high in any state except IDLE/FOUND/EXHAUSTED/ERROR
found  out  1  level; winning nonce held in found_nonce/found_hash
exhausted  out  1  level; range swept, no hit
error  out  1  level; core timeout
found_nonce  out  32  winning nonce (integer)
found_hash  out  256  winning digest, raw core byte order
nonce_cur  out  32  nonce currently in flight
hashes_done  out  32  digests checked since last run (saturates at FFFFFFFF)

Behaviour:
- Reset: state IDLE; all outputs 0; template_q, target_q, nonce_cur, hashes_done cleared.
- States: IDLE, LAUNCH, WAIT, CHECK, DRAIN, FOUND, EXHAUSTED, ERROR.
- IDLE/FOUND/EXHAUSTED/ERROR + run: latch template_in, target, nonce_end into regs; nonce_cur<=nonce_start; clear found/exhausted/error/hashes_done/found_*. Next state LAUNCH. Config inputs are ignored at all other times.
- LAUNCH: hash_start=1 for exactly this cycle; clear timeout counter. Next state WAIT.
- WAIT: on hash_done, capture hash_in into hash_q, increment hashes_done, go to CHECK. Timeout counter increments each cycle; reaching HASH_TIMEOUT -> ERROR (error=1).
- CHECK (1 cycle): value = byte-reverse of hash_q (digest byte 31 becomes MSB).
  - value <= target_q (unsigned, inclusive): found=1, found_nonce=nonce_cur, found_hash=hash_q -> FOUND.
  - else nonce_cur==nonce_end: exhausted=1 -> EXHAUSTED.
  - else nonce_cur<=nonce_cur+1 (mod 2^32) -> LAUNCH.
- Wrap: nonce_end < nonce_start sweeps through FFFFFFFF->00000000. start==end means exactly one hash. start=end+1 means full 2^32 space.
- Abort:
  - In LAUNCH/CHECK: go to IDLE next cycle; no flags set.
  - In WAIT: go to DRAIN. DRAIN waits for hash_done (digest discarded, not counted) or timeout, then IDLE. This prevents a stale done from colliding with the next run. busy stays high in DRAIN.
  - In terminal or IDLE states: no effect.
  - Abort and run in the same cycle: abort wins; stay in current state.
- hash_done outside WAIT/DRAIN is ignored.
- Per-nonce overhead beyond core latency: 2 cycles (LAUNCH, CHECK).
- Reset mid-scan: immediate return to IDLE; the core is reset by the same rst_n.

Decomposition:
- Shared package holds state encodings, header/nonce widths (HDR_W=640, TPL_W=608, NONCE_W=32), and a bswap32 function.
- One sub-module: hash_target_cmp. Combinational byte-reverse plus 256-bit unsigned <= compare; registered output is optional if timing requires a CHECK pipeline stage.

Test Plan:
- Genesis header template (version 1, merkle 4a5e1e4b…, time 495fab29, bits 1d00ffff), target 00000000FFFF0000…00, nonce_start=7C2BAC1B, nonce_end=7C2BAC20 -> found=1, found_nonce=7C2BAC1D, hashes_done=3, found_hash byte-reversed = 000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f.
- Same template, target=0, range 00000010..00000014 -> exhausted=1, hashes_done=5, exactly 5 hash_start pulses, found=0.
- Wrap: target=0, start=FFFFFFFE, end=00000001 -> hash_block[31:0] sequence FEFFFFFF, FFFFFFFF, 00000000, 01000000; exhausted=1, hashes_done=4.
- Target all-ones, start=end=12345678 -> found after 1 hash, found_nonce=12345678, hash_block[31:0]=78563412.
- Abort asserted 50 cycles after launch -> busy stays 1 until hash_done, then IDLE; found=exhausted=0; hashes_done unchanged. A run issued next starts cleanly.
- Stub core that never asserts hash_done -> error=1 exactly HASH_TIMEOUT cycles after hash_start; busy=0; subsequent run clears error.
